// File: rtl/mips_pkg.sv
// Shared datapath constants and forwarding-select encodings used by the operand pipeline.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    FWD_SEL_REG   = 2'd0,
    FWD_SEL_EXMEM = 2'd1,
    FWD_SEL_MEMWB = 2'd2
  } fwd_sel_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Registered valid/ready stage with a one-entry skid; in_ready depends only on local state.
module pipe_skid_buf
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             fire;

  assign in_ready = !skid_valid;
  assign accept   = in_valid & in_ready;
  assign fire     = out_valid & out_ready;

  // Flush drops both entries but leaves the data registers holding their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (fire && skid_valid) begin
      out_data   <= skid_data;
      out_valid  <= 1'b1;
      skid_valid <= 1'b0;
    end else if (accept && (!out_valid || fire)) begin
      out_data   <= in_data;
      out_valid  <= 1'b1;
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end else if (fire) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/operand_sel_pipe.sv
// N:1 operand select feeding a registered skid stage; out-of-range selects fall back to the last input.
module operand_sel_pipe
  import mips_pkg::*;
#(
  parameter  int WIDTH  = WORD_W,
  parameter  int NUM_IN = 3,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    sel_oob
);

  logic [NUM_IN-1:0] hit;
  logic [WIDTH-1:0]  selected;
  logic              oob;
  logic              accept;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_hit
    assign hit[k] = (sel == SEL_W'(k));
  end

  assign oob    = ~|hit;
  assign accept = in_valid & in_ready;

  always_comb begin
    selected = data_in[(NUM_IN-1)*WIDTH +: WIDTH];
    for (int i = 0; i < NUM_IN - 1; i++) begin
      if (hit[i]) selected = data_in[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sel_oob <= 1'b0;
    else if (flush)  sel_oob <= 1'b0;
    else             sel_oob <= accept & oob;
  end

  pipe_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (selected),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Bench for operand_sel_pipe: directed scenarios on the 32x3 build, randomized scoreboard on 8x5.
module tb_operand_sel_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default build: WIDTH=32, NUM_IN=3
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0]  sel = '0;
  logic [95:0] data_in = '0;
  logic        in_ready, out_valid, sel_oob;
  logic [31:0] out_data;

  // Sweep build: WIDTH=8, NUM_IN=5
  logic        fl5 = 1'b0, v5 = 1'b0, ordy5 = 1'b0;
  logic [2:0]  sel5 = '0;
  logic [39:0] din5 = '0;
  logic        r5, ov5, oob5;
  logic [7:0]  od5;

  int checks = 0;
  int passes = 0;

  operand_sel_pipe #(.WIDTH(32), .NUM_IN(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sel_oob(sel_oob)
  );

  operand_sel_pipe #(.WIDTH(8), .NUM_IN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .flush(fl5), .in_valid(v5), .in_ready(r5),
    .sel(sel5), .data_in(din5), .out_valid(ov5), .out_ready(ordy5),
    .out_data(od5), .sel_oob(oob5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] pack3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return {c, b, a};
  endfunction

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_idle_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (out_data !== 32'd0) $display("FAIL reset_idle_out_data got=%h exp=0", out_data); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_idle_in_ready got=%b exp=1", in_ready); else passes++;
    step();
    rst_n = 1'b1;
    step();
    // load an out-of-range beat and hold it, then reset mid-cycle
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 2'd3; data_in = pack3(32'h1, 32'h2, 32'hDEAD);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) $display("FAIL reset_pre_out_valid got=%b exp=1", out_valid); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_async_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (out_data !== 32'd0) $display("FAIL reset_async_out_data got=%h exp=0", out_data); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_async_in_ready got=%b exp=1", in_ready); else passes++;
    checks++; if (sel_oob !== 1'b0) $display("FAIL reset_async_sel_oob got=%b exp=0", sel_oob); else passes++;
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    logic [31:0] exp [3];
    exp[0] = 32'd11; exp[1] = 32'd22; exp[2] = 32'd33;
    out_ready = 1'b1;
    data_in = pack3(32'd11, 32'd22, 32'd33);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== exp[i])
        $display("FAIL stream_beat%0d got v=%b d=%0d exp v=1 d=%0d", i, out_valid, out_data, exp[i]); else passes++;
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL stream_drain got=%b exp=0", out_valid); else passes++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    sel = 2'd0;
    in_valid = 1'b1; data_in = pack3(32'd11, 32'd0, 32'd0);
    step();
    data_in = pack3(32'd22, 32'd0, 32'd0);
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); else passes++;
    checks++; if (out_data !== 32'd11) $display("FAIL bp_hold got=%0d exp=11", out_data); else passes++;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd11)
      $display("FAIL bp_stable got v=%b d=%0d exp v=1 d=11", out_valid, out_data); else passes++;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd22)
      $display("FAIL bp_second got v=%b d=%0d exp v=1 d=22", out_valid, out_data); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_after got=%b exp=1", in_ready); else passes++;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_empty got=%b exp=0", out_valid); else passes++;
  endtask

  task automatic test_default_sel();
    out_ready = 1'b1;
    in_valid = 1'b1; sel = 2'd3; data_in = pack3(32'h1111, 32'h2222, 32'hDEAD);
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 32'hDEAD) $display("FAIL dflt_data got=%h exp=dead", out_data); else passes++;
    checks++; if (sel_oob !== 1'b1) $display("FAIL dflt_oob_pulse got=%b exp=1", sel_oob); else passes++;
    step();
    checks++; if (sel_oob !== 1'b0) $display("FAIL dflt_oob_clear got=%b exp=0", sel_oob); else passes++;
    in_valid = 1'b1; sel = 2'd2; data_in = pack3(32'h1111, 32'h2222, 32'hBEEF);
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 32'hBEEF || sel_oob !== 1'b0)
      $display("FAIL dflt_last_inrange got d=%h oob=%b exp d=beef oob=0", out_data, sel_oob); else passes++;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    sel = 2'd0;
    in_valid = 1'b1; data_in = pack3(32'd5, 32'd0, 32'd0);
    step();
    data_in = pack3(32'd6, 32'd0, 32'd0);
    step();
    checks++; if (in_ready !== 1'b0) $display("FAIL flush_pre_full got=%b exp=0", in_ready); else passes++;
    flush = 1'b1; sel = 2'd3;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_full got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); else passes++;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_no_emit got=%b exp=0", out_valid); else passes++;
    // flush on an empty stage discards the same-cycle accept and its oob flag
    flush = 1'b1; in_valid = 1'b1; sel = 2'd3;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || sel_oob !== 1'b0)
      $display("FAIL flush_accept got v=%b oob=%b exp v=0 oob=0", out_valid, sel_oob); else passes++;
    step();
  endtask

  task automatic test_random_sweep();
    logic [7:0] q[$];
    logic [7:0] words [5];
    logic       exp_oob = 1'b0;
    logic       acc, fir;
    int         idx;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      checks++; if (ov5 !== (q.size() > 0))
        $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, ov5, q.size() > 0); else passes++;
      checks++; if (r5 !== (q.size() < 2))
        $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, r5, q.size() < 2); else passes++;
      checks++; if (oob5 !== exp_oob)
        $display("FAIL rnd_sel_oob cyc=%0d got=%b exp=%b", cyc, oob5, exp_oob); else passes++;
      if (q.size() > 0) begin
        checks++; if (od5 !== q[0])
          $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, od5, q[0]); else passes++;
      end
      v5 = ($urandom_range(0, 3) != 0);
      ordy5 = ($urandom_range(0, 2) != 0);
      fl5 = ($urandom_range(0, 63) == 0);
      sel5 = 3'($urandom_range(0, 7));
      for (int k = 0; k < 5; k++) begin
        words[k] = 8'($urandom);
        din5[k*8 +: 8] = words[k];
      end
      idx = (int'(sel5) >= 4) ? 4 : int'(sel5);
      acc = v5 && (q.size() < 2);
      fir = (q.size() > 0) && ordy5;
      if (fl5) begin
        q.delete();
        exp_oob = 1'b0;
      end else begin
        if (fir) void'(q.pop_front());
        if (acc) q.push_back(words[idx]);
        exp_oob = acc && (sel5 > 3'd4);
      end
      step();
    end
    v5 = 1'b0; fl5 = 1'b0; ordy5 = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (q.size() > 0) begin
        checks++; if (ov5 !== 1'b1 || od5 !== q[0])
          $display("FAIL rnd_drain got v=%b d=%h exp v=1 d=%h", ov5, od5, q[0]); else passes++;
        void'(q.pop_front());
      end
      step();
    end
    checks++; if (ov5 !== 1'b0) $display("FAIL rnd_final_empty got=%b exp=0", ov5); else passes++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_default_sel();
    test_flush();
    test_random_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
